pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised successor to the fixed pipeline stage registers (DOF->EX, EX->WB).
//  A chain of DEPTH stages, each WIDTH bits plus a valid bit, with valid/ready
//  handshake, bubble collapsing, global stall and flush (bubble/NOP injection).
//  Sits between CPU pipeline stages; the controller drives stall/flush on hazards and branches.
// PARAMETERS
//  WIDTH   8   payload bits per stage (control word or bus value)
//  DEPTH   2   number of register stages, >= 1
//  PERF_W  16  width of performance counters (used only with PIPE_PERF_CNT_EN)
// PORTS
//  clk        in   1                  posedge clock
//  reset      in   1                  synchronous, active-low
//  in_valid   in   1                  upstream word present
//  in_data    in   WIDTH              upstream payload
//  in_ready   out  1                  chain accepts in_data this cycle
//  out_valid  out  1                  stage DEPTH-1 holds a word, not stalled
//  out_data   out  WIDTH              payload of stage DEPTH-1
//  out_ready  in   1                  downstream consumes this cycle
//  stall      in   1                  freeze all stages
//  flush      in   1                  invalidate all stages, drop input
//  occupancy  out  $clog2(DEPTH+1)    count of valid stages
//  stall_cnt  out  PERF_W             [PIPE_PERF_CNT_EN only] stalled cycles
//  bubble_cnt out  PERF_W             [PIPE_PERF_CNT_EN only] starved output cycles
// BEHAVIOUR
//  - Reset (reset==0 at posedge): all valid bits 0, all stage data 0, occupancy 0;
//    out_valid 0, out_data 0, in_ready 0 during reset cycle. Reset overrides everything.
//  - Stage k holds v[k], d[k]. Stage 0 is input side, stage DEPTH-1 drives out_data.
//  - Advance (no stall, no flush): adv[DEPTH-1] = v[DEPTH-1] & out_ready.
//    Stage k<DEPTH-1 moves forward when v[k] & (~v[k+1] | adv[k+1]) (bubble collapse).
//  - in_ready = ~stall & ~flush & (~v[0] | adv[0]); combinational. Transfer when in_valid & in_ready.
//  - Stage data loads only when a word enters it; otherwise holds (no toggle on idle).
//  - Stage vacated without refill: v cleared, data held (don't-care, not checked).
//  - Latency: empty chain, word accepted cycle n -> out_valid at cycle n+DEPTH.
//    Throughput 1 word/cycle with out_ready held 1.
//  - out_valid = v[DEPTH-1] & ~stall. out_data = d[DEPTH-1] always (even when stalled).
//  - stall=1: no register changes, in_ready=0, out_valid=0; downstream sees no transfer.
//  - flush=1 (priority over stall): next cycle all v=0, all d=0 (NOP), occupancy 0;
//    input dropped (in_ready=0); output word in stage DEPTH-1 is NOT delivered.
//  - occupancy = popcount(v), registered alongside v.
//  - Full chain (all v=1), out_ready=0: nothing moves, in_ready=0.
//    Full, out_ready=1: whole chain shifts, in_ready=1, input enters stage 0 same edge.
//  - DEPTH=1: single skid-free register, in_ready = ~v[0] | out_ready (when unstalled).
//  - No handshake input is checked for X; in_data is sampled only on transfer.
// CONFIGURATION
//  - Macro PIPE_PERF_CNT_EN.
//  - Defined: stall_cnt increments each cycle stall=1 & flush=0; bubble_cnt increments
//    each cycle out_ready=1 & out_valid=0 & stall=0 & flush=0. Both saturate at all-ones,
//    cleared only by reset (not by flush).
//  - Undefined: stall_cnt, bubble_cnt ports absent; no counter logic; other behaviour identical.
// TESTING
//  - Reset with in_valid=1, data 0xA5, DEPTH=2 -> out_valid=0, occupancy=0, out_data=0x00 throughout reset.
//  - DEPTH=3, out_ready=1, send 0x11,0x22,0x33 back-to-back -> out 0x11/0x22/0x33 on cycles 3,4,5.
//  - DEPTH=2, out_ready=0, send 3 words -> in_ready falls after 2 accepted, occupancy=2;
//    raise out_ready -> 0x01,0x02,0x03 delivered in order, no loss or duplication.
//  - Chain full, stall=1 for 4 cycles with out_ready=1 -> out_valid=0, data frozen;
//    release -> delivery resumes; perf build: stall_cnt=4.
//  - Occupancy 2, flush=1 with in_valid=1 data 0x7E -> next cycle occupancy=0,
//    stage data 0, 0x7E never appears at out_data with out_valid=1.
//  - Perf build, PERF_W=4, 20 starved cycles with out_ready=1 -> bubble_cnt saturates at 0xF.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage valid/ready register chain with bubble collapse, stall and flush.
// Optional perf counters (stall_cnt, bubble_cnt) under PIPE_PERF_CNT_EN.
module pipe_stage_chain #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 2,
  parameter int PERF_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  input  logic                       stall,
  input  logic                       flush,
`ifdef PIPE_PERF_CNT_EN
  output logic [PERF_W-1:0]          stall_cnt,
  output logic [PERF_W-1:0]          bubble_cnt,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
  logic [OCC_W-1:0]            occ_q, occ_d;
  logic [DEPTH-1:0]            adv;
  logic                        go;
  logic                        nxt;
  logic                        xfer;

  // Ripple from the output side: a stage may move if the one ahead
  // is empty or is itself moving this cycle.
  always_comb begin
    go  = reset & ~stall & ~flush;
    nxt = out_ready;
    adv = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      adv[k] = go & v_q[k] & nxt;
      nxt    = ~v_q[k] | adv[k];
    end
    in_ready = go & nxt;
    xfer     = in_valid & in_ready;
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    v_d[0] = xfer | (v_q[0] & ~adv[0]);
    if (xfer) d_d[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      v_d[k] = adv[k-1] | (v_q[k] & ~adv[k]);
      if (adv[k-1]) d_d[k] = d_q[k-1];
    end
    if (flush) begin
      v_d = '0;
      d_d = '0;
    end
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OCC_W'(v_d[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q   <= '0;
      d_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      occ_q <= occ_d;
    end
  end

  assign out_valid = go & v_q[DEPTH-1];
  assign out_data  = reset ? d_q[DEPTH-1] : '0;
  assign occupancy = occ_q;

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] bubble_cnt_q;

  // Saturating; flush deliberately leaves the counts alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall & ~flush & ~&stall_cnt_q)
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (out_ready & ~out_valid & ~stall & ~flush & ~&bubble_cnt_q)
        bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: DEPTH=2 and DEPTH=3 instances on shared inputs,
// checked against a queue-of-positioned-words model.
module tb_pipe_stage_chain;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       stall;
  logic       flush;

  logic       ir [2];
  logic       ov [2];
  logic [7:0] od [2];
  logic [1:0] oc [2];
  logic [3:0] sc [2];
  logic [3:0] bc [2];

  int nvec = 0;
  int nerr = 0;

  pipe_stage_chain #(.WIDTH(8), .DEPTH(2), .PERF_W(4)) u_d2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
    .stall(stall), .flush(flush),
`ifdef PIPE_PERF_CNT_EN
    .stall_cnt(sc[0]), .bubble_cnt(bc[0]),
`endif
    .occupancy(oc[0])
  );

  pipe_stage_chain #(.WIDTH(8), .DEPTH(3), .PERF_W(4)) u_d3 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
    .stall(stall), .flush(flush),
`ifdef PIPE_PERF_CNT_EN
    .stall_cnt(sc[1]), .bubble_cnt(bc[1]),
`endif
    .occupancy(oc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per instance, words oldest-first, each with its stage position.
  int         mcnt [2];
  int         mpos [2][4];
  logic [7:0] mdat [2][4];
  logic [7:0] mtop [2];
  int         msc  [2];
  int         mbc  [2];

  function automatic int dep(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  task automatic mclear(input int i);
    mcnt[i] = 0;
    mtop[i] = 8'h00;
    msc[i]  = 0;
    mbc[i]  = 0;
  endtask

  task automatic eval(input int i, input logic iv, input logic [7:0] dat,
                      input logic ordy, input logic st, input logic fl,
                      input bit commit, output bit ird, output bit ovx);
    int         d;
    int         lim;
    int         nn;
    int         p;
    int         np [4];
    logic [7:0] nd [4];
    logic [7:0] top;
    d   = dep(i);
    ovx = (mcnt[i] > 0) && (mpos[i][0] == d-1) && !st && !fl;
    lim = d;
    nn  = 0;
    top = mtop[i];
    for (int j = 0; j < mcnt[i]; j++) begin
      if (j == 0 && mpos[i][0] == d-1 && ordy) continue;
      p = mpos[i][j] + 1;
      if (p > lim - 1) p = lim - 1;
      if (p == d-1 && mpos[i][j] != d-1) top = mdat[i][j];
      np[nn] = p;
      nd[nn] = mdat[i][j];
      lim    = p;
      nn++;
    end
    ird = !st && !fl && (lim > 0);
    if (commit) begin
      if (st && !fl && msc[i] < 15) msc[i]++;
      if (ordy && !ovx && !st && !fl && mbc[i] < 15) mbc[i]++;
      if (fl) begin
        mcnt[i] = 0;
        mtop[i] = 8'h00;
      end else if (!st) begin
        if (iv && ird) begin
          np[nn] = 0;
          nd[nn] = dat;
          if (d == 1) top = dat;
          nn++;
        end
        mcnt[i] = nn;
        mtop[i] = top;
        for (int j = 0; j < nn; j++) begin
          mpos[i][j] = np[j];
          mdat[i][j] = nd[j];
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int i,
                     input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s[d%0d] observed=%0h expected=%0h",
             tag, dep(i), obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic [7:0] dat,
                      input logic ordy, input logic st, input logic fl);
    bit ird;
    bit ovx;
    reset     = r;
    in_valid  = iv;
    in_data   = dat;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    #1;
    for (int i = 0; i < 2; i++) begin
      eval(i, iv, dat, ordy, st, fl, 1'b0, ird, ovx);
      if (!r) begin
        ird = 1'b0;
        ovx = 1'b0;
      end
      chk("in_ready", i, {7'd0, ir[i]}, {7'd0, ird});
      chk("out_valid", i, {7'd0, ov[i]}, {7'd0, ovx});
      chk("out_data", i, od[i], r ? mtop[i] : 8'h00);
      chk("occupancy", i, {6'd0, oc[i]}, 8'(mcnt[i]));
`ifdef PIPE_PERF_CNT_EN
      chk("stall_cnt", i, {4'd0, sc[i]}, 8'(msc[i]));
      chk("bubble_cnt", i, {4'd0, bc[i]}, 8'(mbc[i]));
`endif
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!r) mclear(i);
      else eval(i, iv, dat, ordy, st, fl, 1'b1, ird, ovx);
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      sc[i] = '0;
      bc[i] = '0;
    end
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mclear(0);
    mclear(1);

    // reset held with a word offered
    repeat (3) step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);

    // back-to-back stream, out_ready high
    step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // back-pressure until full, then drain
    step(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // fill, stall four cycles with out_ready high, release
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b1, 8'(8'h40 + k), 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // flush at occupancy 2 with a word offered
    step(1'b1, 1'b1, 8'h51, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h52, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // starved output long enough to saturate bubble_cnt
    repeat (20) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) != 0),
           1'($urandom),
           8'($urandom),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
